alu_instr_sequencer: RTL

Parametrised control sequencer that drives the datapath control lines through the fetch steps (T0–T2) and execute steps (T3–T6) of register-class ALU instructions. It replaces hand-driven control strobes with a start/done handshake FSM. It sits between the top-level controller and `datapath`. It decodes the IR, distinguishes one-operand, two-operand and HI/LO-writing instructions, stalls on memory, and flags illegal encodings.

---
 rtl/cpu_ctrl_pkg.sv | 68 ++++++
 rtl/ir_class_decoder.sv | 66 ++++++
 rtl/alu_instr_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ALU instruction sequencer.
// Holds ALU function codes, instruction opcodes, the instruction-class and
// sequencer-state enums, IR field positions and a register-range helper.
package cpu_ctrl_pkg;

  // ALU function codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_SHR = 4'b0100;
  localparam logic [3:0] ALU_SHL = 4'b0101;
  localparam logic [3:0] ALU_ROR = 4'b0110;
  localparam logic [3:0] ALU_ROL = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1001;
  localparam logic [3:0] ALU_NEG = 4'b1010;
  localparam logic [3:0] ALU_NOT = 4'b1011;

  // Instruction opcodes
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_SHR = 5'b00111;
  localparam logic [4:0] OP_SHL = 5'b01000;
  localparam logic [4:0] OP_ROR = 5'b01001;
  localparam logic [4:0] OP_ROL = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;

  // IR field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  typedef enum logic [1:0] {
    CLS_ILLEGAL,
    CLS_ONE,
    CLS_TWO,
    CLS_HILO
  } instr_class_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_DONE
  } seq_state_t;

  // A 4-bit register field is only usable when it names an existing register.
  function automatic logic field_in_range(input logic [3:0] f, input int n);
    return $signed({28'd0, f}) < n;
  endfunction

endpackage

// File: rtl/ir_class_decoder.sv
// Combinational IR decoder.
// Ports: opcode/ra/rb/rc fields in; instruction class, ALU code, one-hot
// register selects and the illegal flag out. An illegal instruction reports
// CLS_ILLEGAL and alu_op 0000 so the sequencer never needs a second check.
module ir_class_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [4:0]          opcode,
  input  logic [3:0]          ra,
  input  logic [3:0]          rb,
  input  logic [3:0]          rc,
  output instr_class_t        iclass,
  output logic [3:0]          alu_op,
  output logic [NUM_REGS-1:0] ra_sel,
  output logic [NUM_REGS-1:0] rb_sel,
  output logic [NUM_REGS-1:0] rc_sel,
  output logic                illegal
);

  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] f);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      v[i] = ($signed({28'd0, f}) == i);
    end
    return v;
  endfunction

  instr_class_t cls_raw;
  logic [3:0]   alu_raw;
  logic         regs_ok;

  always_comb begin
    cls_raw = CLS_ILLEGAL;
    alu_raw = ALU_AND;
    unique case (opcode)
      OP_ADD:  begin cls_raw = CLS_TWO;  alu_raw = ALU_ADD; end
      OP_SUB:  begin cls_raw = CLS_TWO;  alu_raw = ALU_SUB; end
      OP_AND:  begin cls_raw = CLS_TWO;  alu_raw = ALU_AND; end
      OP_OR:   begin cls_raw = CLS_TWO;  alu_raw = ALU_OR;  end
      OP_SHR:  begin cls_raw = CLS_TWO;  alu_raw = ALU_SHR; end
      OP_SHL:  begin cls_raw = CLS_TWO;  alu_raw = ALU_SHL; end
      OP_ROR:  begin cls_raw = CLS_TWO;  alu_raw = ALU_ROR; end
      OP_ROL:  begin cls_raw = CLS_TWO;  alu_raw = ALU_ROL; end
      OP_MUL:  begin cls_raw = CLS_HILO; alu_raw = ALU_MUL; end
      OP_DIV:  begin cls_raw = CLS_HILO; alu_raw = ALU_DIV; end
      OP_NEG:  begin cls_raw = CLS_ONE;  alu_raw = ALU_NEG; end
      OP_NOT:  begin cls_raw = CLS_ONE;  alu_raw = ALU_NOT; end
      default: begin cls_raw = CLS_ILLEGAL; alu_raw = ALU_AND; end
    endcase

    // Rc is only read by two-operand instructions
    regs_ok = field_in_range(ra, NUM_REGS) && field_in_range(rb, NUM_REGS) &&
              ((cls_raw != CLS_TWO) || field_in_range(rc, NUM_REGS));

    illegal = (cls_raw == CLS_ILLEGAL) || !regs_ok;
    iclass  = illegal ? CLS_ILLEGAL : cls_raw;
    alu_op  = illegal ? ALU_AND : alu_raw;
    ra_sel  = onehot(ra);
    rb_sel  = onehot(rb);
    rc_sel  = onehot(rc);
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Fetch/execute control sequencer for register-class ALU instructions.
// Ports: clk, reset_n (async active-low), start / mem_ready handshake, ir from
// the datapath; busy/done/illegal status, datapath strobes, alu_op and the
// one-hot gpr_in/gpr_out register selects.
//
// state | meaning
// IDLE  | waiting for start
// T0    | PC to MAR, PC+1 into Z
// T1    | Z to PC, memory read into MDR (holds until mem_ready)
// T2    | MDR to IR
// T3    | first operand out (Y, or straight into ALU for one-operand)
// T4    | second operand into ALU
// T5    | Z low to Ra, or to LO for mul/div
// T6    | Z high to HI (mul/div only)
// DONE  | one-cycle completion pulse, illegal flag valid
//
// Outputs are decoded from the state register and the live IR rather than
// registered one cycle ahead: the IR is only loaded at the end of T2, so a
// precomputed T3 output would see the previous instruction.
module alu_instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IR_W     = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [IR_W-1:0]     ir,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                pc_out,
  output logic                pc_in,
  output logic                inc_pc,
  output logic                mar_in,
  output logic                read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_in,
  output logic                z_low_out,
  output logic                z_high_out,
  output logic                hi_in,
  output logic                lo_in,
  output logic [3:0]          alu_op,
  output logic [NUM_REGS-1:0] gpr_in,
  output logic [NUM_REGS-1:0] gpr_out
);

  seq_state_t          state;
  instr_class_t        iclass;
  logic [3:0]          dec_alu;
  logic [NUM_REGS-1:0] ra_sel, rb_sel, rc_sel;
  logic                dec_illegal;
  logic                unused_ir_bits;

  assign unused_ir_bits = ^ir[RC_LSB-1:0];

  ir_class_decoder #(.NUM_REGS(NUM_REGS)) u_dec (
    .opcode (ir[OPC_MSB:OPC_LSB]),
    .ra     (ir[RA_MSB:RA_LSB]),
    .rb     (ir[RB_MSB:RB_LSB]),
    .rc     (ir[RC_MSB:RC_LSB]),
    .iclass (iclass),
    .alu_op (dec_alu),
    .ra_sel (ra_sel),
    .rb_sel (rb_sel),
    .rc_sel (rc_sel),
    .illegal(dec_illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   if (mem_ready) state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3: begin
          case (iclass)
            CLS_ILLEGAL: state <= S_DONE;
            CLS_ONE:     state <= S_T5;
            default:     state <= S_T4;
          endcase
        end
        S_T4:   state <= S_T5;
        S_T5:   state <= (iclass == CLS_HILO) ? S_T6 : S_DONE;
        S_T6:   state <= S_DONE;
        S_DONE: state <= start ? S_T0 : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state != S_IDLE);
    done       = 1'b0;
    illegal    = 1'b0;
    pc_out     = 1'b0;
    pc_in      = 1'b0;
    inc_pc     = 1'b0;
    mar_in     = 1'b0;
    read       = 1'b0;
    mdr_in     = 1'b0;
    mdr_out    = 1'b0;
    ir_in      = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    z_low_out  = 1'b0;
    z_high_out = 1'b0;
    hi_in      = 1'b0;
    lo_in      = 1'b0;
    alu_op     = ALU_AND;
    gpr_in     = '0;
    gpr_out    = '0;
    case (state)
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
        alu_op = ALU_ADD;
      end
      S_T1: begin
        z_low_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
      end
      S_T3: begin
        case (iclass)
          CLS_ONE:  begin gpr_out = rb_sel; alu_op = dec_alu; z_in = 1'b1; end
          CLS_TWO:  begin gpr_out = rb_sel; y_in = 1'b1; end
          CLS_HILO: begin gpr_out = ra_sel; y_in = 1'b1; end
          default:  ;
        endcase
      end
      S_T4: begin
        case (iclass)
          CLS_TWO:  begin gpr_out = rc_sel; alu_op = dec_alu; z_in = 1'b1; end
          CLS_HILO: begin gpr_out = rb_sel; alu_op = dec_alu; z_in = 1'b1; end
          default:  ;
        endcase
      end
      S_T5: begin
        z_low_out = 1'b1;
        // guard against an IR that changed to an illegal encoding mid-execute
        if (iclass == CLS_HILO)         lo_in  = 1'b1;
        else if (iclass != CLS_ILLEGAL) gpr_in = ra_sel;
      end
      S_T6: begin
        z_high_out = 1'b1;
        hi_in      = (iclass == CLS_HILO);
      end
      S_DONE: begin
        done    = 1'b1;
        illegal = dec_illegal;
      end
      default: ;
    endcase
  end

endmodule
